// File: rtl/mem_bank_pkg.sv
// mem_bank_pkg: access-mode encoding shared by the memory bank files
package mem_bank_pkg;
  typedef logic [1:0] mode_t;
  localparam mode_t MODE_RAM    = 2'b00;
  localparam mode_t MODE_FIFO   = 2'b01;
  localparam mode_t MODE_STREAM = 2'b10;
  localparam mode_t MODE_RSVD   = 2'b11;
endpackage

// File: rtl/mem_bank_array.sv
// mem_bank_array: DEPTH x DATA_W storage, one write port, one synchronous read-first read port, no reset
module mem_bank_array #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              re,
  input  logic [ADDR_W-1:0] ra,
  output logic [DATA_W-1:0] q
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) q <= mem[ra];
  end
endmodule

// File: rtl/mem_bank_ctl.sv
// mem_bank_ctl: RAM/FIFO/STREAM memory bank; mode register, pointers, FIFO count/flags, sticky errors, 1-cycle read with rvalid
module mem_bank_ctl
  import mem_bank_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic              ptr_ld,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              err_ovf,
  output logic              err_udf,
  input  logic              clr_err
);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  mode_t             mode_q;
  logic [ADDR_W-1:0] wptr, rptr, sptr, wp, rp, sp, wptr_n, rptr_n, sptr_n, wa, ra;
  logic [ADDR_W:0]   count_q, ce, count_n;
  logic              chg, is_ram, is_fifo, is_str, f_full, f_empty;
  logic              push, pop, ovf, udf, we, re, rd_clr;
  logic [DATA_W-1:0] q;
  always_comb begin
    chg     = mode != mode_q;
    is_ram  = mode == MODE_RAM;
    is_fifo = mode == MODE_FIFO;
    is_str  = mode == MODE_STREAM;
    wp      = chg ? '0 : wptr;
    rp      = chg ? '0 : rptr;
    ce      = chg ? '0 : count_q;
    sp      = ptr_ld ? addr : (chg ? '0 : sptr);
    f_full  = ce == FULL_CNT;
    f_empty = ce == '0;
    push    = is_fifo && wr_en && (!f_full || rd_en);
    pop     = is_fifo && rd_en && !f_empty;
    ovf     = is_fifo && wr_en && f_full && !rd_en;
    udf     = is_fifo && rd_en && f_empty;
    we      = rst_n && ((is_ram && wr_en) || push || (is_str && wr_en));
    re      = rst_n && ((is_ram && rd_en) || pop || (is_str && rd_en));
    wa      = is_fifo ? wp : (is_str ? sp : addr);
    ra      = is_fifo ? rp : (is_str ? sp : addr);
    wptr_n  = wp + ADDR_W'(push);
    rptr_n  = rp + ADDR_W'(pop);
    count_n = ce + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
    sptr_n  = is_str ? sp + ADDR_W'(wr_en || rd_en) : (chg ? '0 : sptr);
  end
  always_ff @(posedge clk) begin
    mode_q <= mode;
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      sptr    <= '0;
      count_q <= '0;
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
      rvalid  <= 1'b0;
      rd_clr  <= 1'b1;
    end else begin
      wptr    <= wptr_n;
      rptr    <= rptr_n;
      sptr    <= sptr_n;
      count_q <= count_n;
      err_ovf <= ovf || (err_ovf && !clr_err);
      err_udf <= udf || (err_udf && !clr_err);
      rvalid  <= re;
      if (re) rd_clr <= 1'b0;
    end
  end
  mem_bank_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_array (
    .clk(clk), .we(we), .wa(wa), .wd(wdata), .re(re), .ra(ra), .q(q)
  );
  assign rdata = rd_clr ? '0 : q;
  assign count = count_q;
  assign full  = count_q == FULL_CNT;
  assign empty = count_q == '0;
endmodule

// File: tb/tb_mem_bank_ctl.sv
// tb_mem_bank_ctl: scoreboard bench for mem_bank_ctl against a queue/array reference model
module tb_mem_bank_ctl;
  localparam int DW = 8, D = 16, AW = 4;
  logic clk = 0, rst_n = 0, ptr_ld = 0, wr_en = 0, rd_en = 0, clr_err = 0;
  logic [1:0] mode = 0;
  logic [AW-1:0] addr = 0;
  logic [DW-1:0] wdata = 0, rdata;
  logic rvalid, full, empty, err_ovf, err_udf;
  logic [AW:0] count;
  always #5 clk = ~clk;
  mem_bank_ctl #(.DATA_W(DW), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .addr(addr), .ptr_ld(ptr_ld), .wr_en(wr_en),
    .wdata(wdata), .rd_en(rd_en), .rdata(rdata), .rvalid(rvalid), .full(full), .empty(empty),
    .count(count), .err_ovf(err_ovf), .err_udf(err_udf), .clr_err(clr_err)
  );
  int passed = 0, total = 0;
  logic [DW-1:0] mm [D];
  logic [DW-1:0] sb [$];
  int head = 0, size = 0, sp = 0;
  bit eo = 0, eu = 0, mon_en = 0;
  logic [1:0] mq = 0;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  always @(posedge clk) begin : model
    bit no, nu, pop_ok, push_ok;
    if (!rst_n) begin
      sb.delete(); head = 0; size = 0; sp = 0; eo = 0; eu = 0; mq = mode;
    end else begin
      no = 0; nu = 0;
      if (mode != mq) begin head = 0; size = 0; sp = 0; mq = mode; end
      if (mode == 2'b00) begin
        if (rd_en) sb.push_back(mm[addr]);
        if (wr_en) mm[addr] = wdata;
      end else if (mode == 2'b01) begin
        pop_ok  = rd_en && size > 0;
        push_ok = wr_en && (size < D || rd_en);
        nu = rd_en && size == 0;
        no = wr_en && size == D && !rd_en;
        if (pop_ok) sb.push_back(mm[head]);
        if (push_ok) mm[(head + size) % D] = wdata;
        if (pop_ok) head = (head + 1) % D;
        size += int'(push_ok) - int'(pop_ok);
      end else if (mode == 2'b10) begin
        if (ptr_ld) sp = int'(addr);
        if (rd_en) sb.push_back(mm[sp]);
        if (wr_en) mm[sp] = wdata;
        if (rd_en || wr_en) sp = (sp + 1) % D;
      end
      eo = no || (eo && !clr_err);
      eu = nu || (eu && !clr_err);
    end
  end
  always @(negedge clk) if (mon_en) begin
    if (sb.size() > 0) begin
      chk("rvalid", int'(rvalid), 1);
      chk("rdata", int'(rdata), int'(sb.pop_front()));
    end else chk("rvalid_idle", int'(rvalid), 0);
    chk("count", int'(count), size);
    chk("full", int'(full), int'(size == D));
    chk("empty", int'(empty), int'(size == 0));
    chk("err_ovf", int'(err_ovf), int'(eo));
    chk("err_udf", int'(err_udf), int'(eu));
  end
  task automatic cyc(input int m, input int a, input bit pl, input bit w, input int d, input bit r, input bit c);
    mode = 2'(m); addr = AW'(a); ptr_ld = pl; wr_en = w; wdata = DW'(d); rd_en = r; clr_err = c;
    @(negedge clk);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    mon_en = 1;
    chk("rst_rdata", int'(rdata), 0);
    chk("rst_empty", int'(empty), 1);
    rst_n = 1;
    for (int i = 0; i < D; i++) cyc(0, i, 0, 1, int'($urandom_range(255)), 0, 0);
    cyc(0, 3, 0, 1, 'hA5, 0, 0);
    cyc(0, 15, 0, 1, 'h5A, 0, 0);
    cyc(0, 3, 0, 0, 0, 1, 0);
    chk("ram_rd3", int'(rdata), 'hA5);
    cyc(0, 15, 0, 0, 0, 1, 0);
    chk("ram_rd15", int'(rdata), 'h5A);
    cyc(0, 3, 0, 1, 'h11, 1, 0);
    chk("ram_read_first", int'(rdata), 'hA5);
    for (int i = 0; i < D; i++) cyc(1, 0, 0, 1, i, 0, 0);
    chk("fifo_full", int'(full), 1);
    cyc(1, 0, 0, 1, 'hFF, 0, 0);
    chk("fifo_ovf", int'(err_ovf), 1);
    chk("fifo_ovf_cnt", int'(count), 16);
    cyc(1, 0, 0, 1, 'h77, 1, 0);
    chk("full_pushpop", int'(rdata), 'h00);
    chk("full_pushpop_cnt", int'(count), 16);
    for (int i = 0; i < D; i++) cyc(1, 0, 0, 0, 0, 1, 0);
    chk("drain_last", int'(rdata), 'h77);
    chk("drain_empty", int'(empty), 1);
    cyc(1, 0, 0, 1, 'h33, 1, 1);
    chk("empty_pushpop_rv", int'(rvalid), 0);
    chk("empty_pushpop_udf", int'(err_udf), 1);
    chk("empty_pushpop_cnt", int'(count), 1);
    cyc(1, 0, 0, 0, 0, 1, 1);
    chk("pop_33", int'(rdata), 'h33);
    cyc(2, 14, 1, 1, 'hB0, 0, 0);
    cyc(2, 0, 0, 1, 'hB1, 0, 0);
    cyc(2, 0, 0, 1, 'hB2, 0, 0);
    cyc(2, 14, 1, 0, 0, 1, 0);
    chk("str_rd0", int'(rdata), 'hB0);
    cyc(2, 0, 0, 0, 0, 1, 0);
    cyc(2, 0, 0, 0, 0, 1, 0);
    chk("str_rd2", int'(rdata), 'hB2);
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 1, 'hC0 + i, 0, 0);
    chk("fifo5_cnt", int'(count), 5);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("sw_ram_rd0", int'(rdata), 'hC0);
    chk("sw_ram_cnt", int'(count), 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("sw_fifo_empty", int'(empty), 1);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, i, 0, 0);
    rst_n = 0;
    cyc(1, 0, 0, 0, 0, 1, 0);
    chk("rst_mid_rv", int'(rvalid), 0);
    chk("rst_mid_rdata", int'(rdata), 0);
    chk("rst_mid_cnt", int'(count), 0);
    rst_n = 1;
    for (int i = 0; i < D; i++) cyc(1, 0, 0, 1, i, 0, 0);
    cyc(1, 0, 0, 1, 'hEE, 0, 1);
    chk("clr_vs_ovf", int'(err_ovf), 1);
    begin
      int m = 0;
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(19) == 0) m = int'($urandom_range(3));
        cyc(m, int'($urandom_range(D - 1)), $urandom_range(7) == 0, 1'($urandom), int'($urandom_range(255)),
            1'($urandom), $urandom_range(15) == 0);
      end
    end
    cyc(3, 0, 0, 0, 0, 0, 0);
    cyc(3, 0, 0, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_bank_ctl.md
Name: mem_bank_ctl

Overview:
Parametrised on-chip memory bank with three run-time access modes: random-access RAM, FIFO and auto-incrementing stream.
It succeeds the fixed 16x8 single-mode memory.
It sits behind the project top level, which maps the dedicated and bidirectional IO pins onto its ports.
It adds FIFO occupancy flags, sticky error flags, a stream pointer and read-valid signalling.

Parameters:
DATA_W, 8, word width in bits (1..32)
DEPTH, 16, number of words; power of two, minimum 2
ADDR_W, $clog2(DEPTH), address/pointer width (derived; do not override)

Ports:
clk  in  1  clock; all logic rising-edge
rst_n  in  1  synchronous, active-low reset
mode  in  2  00 RAM, 01 FIFO, 10 STREAM, 11 reserved (idle)
addr  in  ADDR_W  RAM address; stream pointer load value
ptr_ld  in  1  STREAM only: load stream pointer from addr
wr_en  in  1  write/push strobe
wdata  in  DATA_W  write data
rd_en  in  1  read/pop strobe
rdata  out  DATA_W  registered read data
rvalid  out  1  rdata updated this cycle (one-cycle pulse)
full  out  1  FIFO count == DEPTH
empty  out  1  FIFO count == 0
count  out  ADDR_W+1  FIFO occupancy
err_ovf  out  1  sticky: push while full without pop
err_udf  out  1  sticky: pop while empty
clr_err  in  1  clears both sticky errors

Behaviour:
- Reset (rst_n=0 at clk edge):
  - rdata=0, rvalid=0, wptr=rptr=sptr=0, count=0, empty=1, full=0, err_ovf=err_udf=0.
  - Memory contents are not reset.
- All read latency is 1 cycle: the strobe is sampled at edge N; rdata and rvalid are valid after edge N; rvalid is high for exactly one cycle per accepted read.
- rdata holds its last value whenever no read is accepted.
- mode_q registers mode. When mode != mode_q at an edge:
  - wptr, rptr, sptr and count clear to 0; contents and error flags are retained.
  - Strobes in that cycle are still executed under the new mode with the cleared pointers.
- RAM (00):
  - wr_en: mem[addr] <= wdata.
  - rd_en: rdata <= mem[addr].
  - Read-during-write to the same address returns the OLD data (read-first).
- FIFO (01):
  - A push is accepted if wr_en && (!full || rd_en); it writes mem[wptr] and increments wptr.
  - A pop is accepted if rd_en && !empty; rdata <= mem[rptr] and rptr increments.
  - count += push - pop.
  - Simultaneous push and pop when full: both accepted, count unchanged.
  - Simultaneous push and pop when empty: push accepted, pop rejected (no fall-through), err_udf set.
  - Rejected push sets err_ovf; data is dropped and state is unchanged.
  - Pointers wrap DEPTH-1 -> 0 by natural ADDR_W overflow.
- STREAM (10):
  - ptr_ld has priority over the increment: sptr <= addr; strobes in the same cycle use the NEW value addr.
  - wr_en: mem[sptr] <= wdata.
  - rd_en: rdata <= mem[sptr] (old data if also writing).
  - sptr increments once if wr_en || rd_en. It wraps to 0 after DEPTH-1.
  - full/empty/count hold 0/1/0 in this mode.
- Reserved (11): no writes, no reads, rvalid=0, pointers hold.
- full, empty and count outputs are valid in all modes. In modes other than FIFO they read 0, 1 and 0.
- Error flags:
  - clr_err clears both flags.
  - If clr_err coincides with a new error event, the new error wins (the flag stays set).
- Reset mid-operation discards any in-flight read: rvalid is 0 on the cycle after reset.

Decomposition:
- Package mem_bank_pkg:
  - mode constants MODE_RAM=2'b00, MODE_FIFO=2'b01, MODE_STREAM=2'b10, MODE_RSVD=2'b11;
  - a typedef for the 2-bit mode.
- Sub-module mem_bank_array:
  - DEPTH x DATA_W storage; one write port; one synchronous read-first read port.
  - No reset; swappable for a hard macro.
- mem_bank_ctl holds the mode register, pointers, count, flags and the rvalid/rdata register.

Test Plan:
All scenarios use DATA_W=8, DEPTH=16.
1. RAM: write 0xA5@3, 0x5A@15; read 3 then 15 -> rdata 0xA5 then 0x5A, each with one rvalid pulse; same-cycle write 0x11@3 with read@3 -> rdata 0xA5.
2. FIFO fill/drain: push 0x00..0x0F -> full=1, count=16; extra push 0xFF -> err_ovf=1, count stays 16; 16 pops -> 0x00..0x0F in order, then empty=1.
3. FIFO boundary: when full, push 0x77 with pop -> rdata 0x00, count 16, no err_ovf; when empty, push 0x33 with pop -> rvalid=0, err_udf=1, count=1; next pop -> 0x33.
4. STREAM: ptr_ld addr=14, write 0xB0,0xB1,0xB2 -> mem[14]=0xB0, mem[15]=0xB1, mem[0]=0xB2; ptr_ld 14 and three reads -> 0xB0,0xB1,0xB2.
5. Mode switch: FIFO with count=5 switched to RAM and back to FIFO -> count=0, empty=1; RAM read@0 returns the data written in FIFO.
6. Reset mid-read: rd_en with rst_n=0 on the same edge -> rvalid=0, rdata=0, count=0; err flags cleared; clr_err concurrent with an overflow leaves err_ovf=1.
